// File: rtl/fb_cmd_pkg.sv
// fb_cmd_pkg: shared definitions for the framebuffer command sequencer.
//   - opcode constants (OP_NOP, OP_WRITE, OP_FILL)
//   - FSM state enum (FILL_VAL / FILL only when FB_CMD_FILL_EN is defined)
//   - small helpers: opcode validity, CNT decoding, timeout-window states
// Configuration macro: FB_CMD_FILL_EN enables the FILL command.
package fb_cmd_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_H   = 3'd1,
    S_ADDR_L   = 3'd2,
    S_COUNT    = 3'd3,
    S_DATA     = 3'd4,
`ifdef FB_CMD_FILL_EN
    S_FILL_VAL = 3'd5,
    S_FILL     = 3'd6,
`endif
    S_DONE     = 3'd7
  } state_e;

  // Opcodes that start a multi-byte packet.
  function automatic logic is_valid_op(input logic [7:0] op);
`ifdef FB_CMD_FILL_EN
    return (op == OP_WRITE) || (op == OP_FILL);
`else
    return (op == OP_WRITE);
`endif
  endfunction

  // CNT byte to number of writes: zero encodes a full 256.
  function automatic logic [8:0] count_len(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
  endfunction

  // States in which the decoder owes us more bytes.
  function automatic logic in_packet(input state_e s);
    case (s)
      S_ADDR_H, S_ADDR_L, S_COUNT, S_DATA: return 1'b1;
`ifdef FB_CMD_FILL_EN
      S_FILL_VAL:                          return 1'b1;
`endif
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_skid.sv
// byte_skid: one-entry byte buffer in front of the command FSM.
// A strobed byte is offered to the consumer in the same cycle (bypass);
// if the consumer does not take it, it is parked here. A byte arriving
// while the entry is occupied is dropped and flagged.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   in_flag       byte strobe, in_data valid
//   in_data       incoming byte
//   take          consumer accepts the current head this cycle
//   avail         a byte is offered (parked or bypassed)
//   head          the offered byte
//   full_nxt      occupancy after this edge (for registered busy)
//   ovr           byte dropped this cycle (entry already full)
module byte_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_flag,
  input  logic [7:0] in_data,
  input  logic       take,
  output logic       avail,
  output logic [7:0] head,
  output logic       full_nxt,
  output logic       ovr
);

  logic       full;
  logic [7:0] data;

  assign avail = full | in_flag;
  assign head  = full ? data : in_data;
  assign ovr   = full & in_flag;

  always_comb begin
    full_nxt = full;
    if (full) begin
      if (take) full_nxt = 1'b0;
    end else if (in_flag && !take) begin
      full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the holding register is reset as well, so head is never X after reset.
    if (!rst) begin
      full <= 1'b0;
      data <= 8'h00;
    end else begin
      full <= full_nxt;
      if (!full && in_flag && !take) data <= in_data;
    end
  end

endmodule

// File: rtl/fb_cmd_ctrl.sv
// fb_cmd_ctrl: parses the decoded COBS byte stream into WRITE / FILL
// commands and issues one framebuffer write per data byte.
// Packet: OP, ADDR_H, ADDR_L, CNT, payload (CNT=0 means 256).
// Configuration macro: FB_CMD_FILL_EN compiles in the FILL command;
// without it 0x02 is an unknown opcode.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_flag, in_data    decoded byte strobe and byte
//   busy                decoder must not strobe while high
//   mem_we/addr/wdata   write request, held until mem_ready
//   mem_ready           write accepted when mem_we & mem_ready
//   pkt_done            one-cycle pulse after the last write of a packet
//   err_op/ovr/tmo      sticky: unknown opcode, skid overrun, timeout
module fb_cmd_ctrl
  import fb_cmd_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 270000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_flag,
  input  logic [7:0]    in_data,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ready,
  output logic          pkt_done,
  output logic          err_op,
  output logic          err_ovr,
  output logic          err_tmo
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state, state_d;
  logic [7:0]    addr_h, addr_h_d;
  logic [AW-1:0] addr_d;
  logic [8:0]    rem, rem_d;
  logic [7:0]    wdata_d;
  logic          we_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic          err_op_d, err_ovr_d, err_tmo_d;
  logic          busy_d, pkt_done_d, stall_state;
  logic          take, avail, full_nxt, ovr;
  logic [7:0]    head;
  logic          accept, slot_free;
`ifdef FB_CMD_FILL_EN
  logic          is_fill, is_fill_d;
`endif

  byte_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_flag  (in_flag),
    .in_data  (in_data),
    .take     (take),
    .avail    (avail),
    .head     (head),
    .full_nxt (full_nxt),
    .ovr      (ovr)
  );

  assign accept    = mem_we & mem_ready;
  // A new write may be loaded when nothing is pending or the pending one retires now.
  assign slot_free = ~mem_we | mem_ready;

  always_comb begin
    // NOTE: every next value is defaulted first, so no branch can infer a latch.
    state_d   = state;
    addr_h_d  = addr_h;
    addr_d    = mem_addr;
    rem_d     = rem;
    wdata_d   = mem_wdata;
    we_d      = mem_we;
    tmo_d     = tmo_cnt;
    err_op_d  = err_op;
    err_ovr_d = err_ovr | ovr;
    err_tmo_d = err_tmo;
    take      = 1'b0;
`ifdef FB_CMD_FILL_EN
    is_fill_d = is_fill;
`endif

    // Handshake retirement is independent of state, so a write left pending
    // by a timeout abort still completes.
    if (accept) begin
      we_d   = 1'b0;
      addr_d = mem_addr + AW'(1);
    end

    case (state)
      S_IDLE: begin
        if (avail && !mem_we) begin
          take = 1'b1;
          if (is_valid_op(head)) begin
            state_d = S_ADDR_H;
`ifdef FB_CMD_FILL_EN
            is_fill_d = (head == OP_FILL);
`endif
          end else if (head != OP_NOP) begin
            err_op_d = 1'b1;
          end
        end
      end
      S_ADDR_H: begin
        if (avail && !mem_we) begin
          take     = 1'b1;
          addr_h_d = head;
          state_d  = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (avail && !mem_we) begin
          take    = 1'b1;
          addr_d  = AW'({addr_h, head});
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (avail && !mem_we) begin
          take  = 1'b1;
          rem_d = count_len(head);
`ifdef FB_CMD_FILL_EN
          state_d = is_fill ? S_FILL_VAL : S_DATA;
`else
          state_d = S_DATA;
`endif
        end
      end
      S_DATA: begin
        // rem counts writes not yet issued; rem==0 means wait for the last handshake.
        if (rem != 9'd0) begin
          if (avail && slot_free) begin
            take    = 1'b1;
            we_d    = 1'b1;
            wdata_d = head;
            rem_d   = rem - 9'd1;
          end
        end else if (accept) begin
          state_d = S_DONE;
        end
      end
`ifdef FB_CMD_FILL_EN
      S_FILL_VAL: begin
        if (avail && !mem_we) begin
          take    = 1'b1;
          wdata_d = head;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (rem != 9'd0) begin
          if (slot_free) begin
            we_d  = 1'b1;
            rem_d = rem - 9'd1;
          end
        end else if (accept) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout: a strobe always clears it, a pending write freezes it.
    if (!in_packet(state) || in_flag) begin
      tmo_d = '0;
    end else if (!mem_we) begin
      if (tmo_cnt == TW'(TIMEOUT - 1)) begin
        tmo_d     = '0;
        err_tmo_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_cnt + TW'(1);
      end
    end

    stall_state = (state_d == S_DONE);
`ifdef FB_CMD_FILL_EN
    if (state_d == S_FILL) stall_state = 1'b1;
`endif
    busy_d     = full_nxt | we_d | stall_state;
    pkt_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_h    <= 8'h00;
      mem_addr  <= '0;
      rem       <= 9'd0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      tmo_cnt   <= '0;
      err_op    <= 1'b0;
      err_ovr   <= 1'b0;
      err_tmo   <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
`ifdef FB_CMD_FILL_EN
      is_fill   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state     <= state_d;
      addr_h    <= addr_h_d;
      mem_addr  <= addr_d;
      rem       <= rem_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      tmo_cnt   <= tmo_d;
      err_op    <= err_op_d;
      err_ovr   <= err_ovr_d;
      err_tmo   <= err_tmo_d;
      busy      <= busy_d;
      pkt_done  <= pkt_done_d;
`ifdef FB_CMD_FILL_EN
      is_fill   <= is_fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_fb_cmd_ctrl.sv
// tb_fb_cmd_ctrl: self-checking bench for fb_cmd_ctrl.
// A stream-level reference model turns the sent byte stream into the
// expected list of (address, data) writes, packet completions and opcode
// errors; a negedge monitor records what the DUT actually wrote.
// Honours FB_CMD_FILL_EN the same way as the design.
module tb_fb_cmd_ctrl;

  localparam int AW  = 16;
  localparam int TMO = 40;
`ifdef FB_CMD_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_flag = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          busy, mem_we, pkt_done, err_op, err_ovr, err_tmo;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  fb_cmd_ctrl #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flag   (in_flag),
    .in_data   (in_data),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .pkt_done  (pkt_done),
    .err_op    (err_op),
    .err_ovr   (err_ovr),
    .err_tmo   (err_tmo)
  );

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [63:0] bytes;   // first byte in the top octet
    int          len;
    int          rmode;   // 0 ready, 1 toggle, 2 random, 3 stalled
    int          exp_nwr;
    int          exp_done;
    bit          exp_err_op;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [23:0] act_wr[$];
  logic [23:0] exp_wr[$];
  int          act_done = 0;
  int          exp_done = 0;
  bit          exp_err_op = 1'b0;
  int          ready_mode = 0;
  int          cyc = 0;
  int          last_hs = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_ad = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mem_ready pattern for the current phase.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ~mem_ready;
      2:       mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
  end

  // Write / completion monitor plus stall-stability check.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, prev_ad});
      if (mem_we && mem_ready) begin
        act_wr.push_back({mem_addr, mem_wdata});
        last_hs = cyc;
      end
      if (pkt_done) begin
        act_done++;
        check("done_after_hs", cyc - last_hs, 1);
      end
      prev_stall = mem_we && !mem_ready;
      prev_ad    = {mem_addr, mem_wdata};
    end
  end

  // Reference model: parse a complete byte stream into expected writes.
  task automatic model_parse(input bq_t s);
    int          i;
    int          n;
    logic [7:0]  op;
    logic [7:0]  d;
    logic [15:0] a;
    i = 0;
    while (i < s.size()) begin
      op = s[i];
      i++;
      if (op == 8'h01 || (FILL_EN && op == 8'h02)) begin
        if (i + 3 > s.size()) break;
        a = {s[i], s[i+1]};
        n = (s[i+2] == 8'h00) ? 256 : int'(s[i+2]);
        i += 3;
        for (int k = 0; k < n; k++) begin
          d = (op == 8'h01) ? s[i+k] : s[i];
          exp_wr.push_back({a + 16'(k), d});
        end
        i += (op == 8'h01) ? n : 1;
        exp_done++;
      end else if (op != 8'h00) begin
        exp_err_op = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    in_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    act_wr.delete();
    exp_wr.delete();
    act_done   = 0;
    exp_done   = 0;
    exp_err_op = 1'b0;
  endtask

  // Called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (busy && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_wait: busy still 1 after %0d cycles, required 0", w);
    end
    in_flag = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    in_flag = 1'b0;
  endtask

  task automatic send_stream(input bq_t s);
    foreach (s[k]) send_byte(s[k]);
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    int t;
    quiet = 0;
    t     = 0;
    while (quiet < 4 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
      if (!busy && !mem_we) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_idle: busy after %0d cycles, required idle", name, t);
    end
  endtask

  // Compare recorded writes and completions against the model, then clear.
  task automatic finish_case(input string name);
    int n;
    check({name, "_nwr"}, act_wr.size(), exp_wr.size());
    n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int k = 0; k < n; k++) check({name, "_wr"}, act_wr[k], exp_wr[k]);
    check({name, "_done"}, act_done, exp_done);
    act_wr.delete();
    exp_wr.delete();
    act_done = 0;
    exp_done = 0;
  endtask

  initial begin
    vec_t        tbl[5];
    bq_t         s;
    int          r;
    int          cnt;
    logic [7:0]  x;

    tbl[0] = '{64'h01_00_10_03_AA_BB_CC_00, 7, 0, 3, 1, 1'b0};
    tbl[1] = '{64'h7E_01_12_34_01_5A_00_00, 6, 0, 1, 1, 1'b1};
    tbl[2] = '{64'h00_01_00_FF_02_11_22_00, 7, 1, 2, 1, 1'b0};
`ifdef FB_CMD_FILL_EN
    tbl[3] = '{64'h02_FF_FE_04_55_00_00_00, 5, 1, 4, 1, 1'b0};
`else
    tbl[3] = '{64'h02_FF_FE_04_55_00_00_00, 5, 1, 0, 0, 1'b1};
`endif
    tbl[4] = '{64'h01_FF_FF_02_01_02_00_00, 6, 2, 2, 1, 1'b0};

    // Reset values.
    ready_mode = 0;
    do_reset();
    check("rst_busy",  busy, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done",  pkt_done, 0);
    check("rst_errs",  {err_op, err_ovr, err_tmo}, 0);

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      ready_mode = tbl[v].rmode;
      s = {};
      for (int k = 0; k < tbl[v].len; k++) s.push_back(tbl[v].bytes[63 - 8*k -: 8]);
      model_parse(s);
      send_stream(s);
      wait_idle($sformatf("vec%0d", v));
      check($sformatf("vec%0d_nwr_tbl", v), act_wr.size(), tbl[v].exp_nwr);
      check($sformatf("vec%0d_done_tbl", v), act_done, tbl[v].exp_done);
      check($sformatf("vec%0d_err_op", v), err_op, tbl[v].exp_err_op);
      check($sformatf("vec%0d_err_ovr_tmo", v), {err_ovr, err_tmo}, 0);
      finish_case($sformatf("vec%0d", v));
    end

    // Data-byte latency: strobe at T, mem_we at T+1, busy low at T+2.
    do_reset();
    ready_mode = 0;
    s = {8'h01, 8'h00, 8'h20, 8'h02, 8'h99, 8'h77};
    model_parse(s);
    send_stream(s[0:3]);
    in_flag = 1'b1;
    in_data = 8'h99;
    @(posedge clk);
    #1;
    in_flag = 1'b0;
    check("lat_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0020, 8'h99});
    @(posedge clk);
    #1;
    check("lat_busy", busy, 0);
    send_byte(8'h77);
    wait_idle("lat");
    finish_case("lat");

    // CNT=0: 256 writes.
    do_reset();
    ready_mode = 0;
    s = {8'h01, 8'h12, 8'h00, 8'h00};
    for (int k = 0; k < 256; k++) s.push_back(8'($urandom_range(0, 255)));
    model_parse(s);
    send_stream(s);
    wait_idle("cnt0");
    check("cnt0_n256", act_wr.size(), 256);
    finish_case("cnt0");

    // Timeout mid-header, then a normal packet.
    do_reset();
    ready_mode = 0;
    send_stream({8'h01, 8'h00, 8'h00});
    repeat (TMO - 5) @(posedge clk);
    #1;
    check("tmo_early", err_tmo, 0);
    repeat (10) @(posedge clk);
    #1;
    check("tmo_set", {err_tmo, busy, mem_we}, 3'b100);
    finish_case("tmo_abort");
    s = {8'h01, 8'h00, 8'h30, 8'h01, 8'hE7};
    model_parse(s);
    send_stream(s);
    wait_idle("tmo_next");
    finish_case("tmo_next");

    // Overrun: two strobes while busy with mem_ready=0.
    do_reset();
    ready_mode = 3;
    send_stream({8'h01, 8'h00, 8'h40, 8'h02});
    foreach (s[k]) s.delete(k);
    s = {8'h01, 8'h00, 8'h40, 8'h02, 8'hC1, 8'hC2};
    model_parse(s);
    in_flag = 1'b1;
    in_data = 8'hC1;
    @(posedge clk);
    #1;
    check("ovr_busy", {busy, mem_we}, 2'b11);
    in_data = 8'hC2;
    @(posedge clk);
    #1;
    in_data = 8'hC3;
    @(posedge clk);
    #1;
    in_flag = 1'b0;
    check("ovr_flag", err_ovr, 1);
    ready_mode = 0;
    wait_idle("ovr");
    finish_case("ovr");

    // Reset while a write is stalled.
    do_reset();
    send_byte(8'h7E);
    ready_mode = 3;
    send_stream({8'h01, 8'h00, 8'h50, 8'h01, 8'h33});
    repeat (3) @(posedge clk);
    #1;
    check("rstw_pending", {mem_we, err_op}, 2'b11);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_cleared", {mem_we, busy, pkt_done, err_op, err_ovr, err_tmo}, 0);
    check("rstw_addr", mem_addr, 0);
    rst = 1'b1;
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    finish_case("rstw");

    // Randomized packet stream against the model.
    do_reset();
    ready_mode = 2;
    s = {};
    for (int p = 0; p < 16; p++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        s.push_back(8'h00);
      end else if (r == 1) begin
        s.push_back(8'($urandom_range(128, 255)));
      end else begin
        cnt = $urandom_range(1, 8);
        s.push_back((r <= 3 && FILL_EN) ? 8'h02 : 8'h01);
        s.push_back(8'($urandom_range(0, 255)));
        s.push_back(8'($urandom_range(0, 255)));
        s.push_back(8'(cnt));
        x = s[s.size() - 4];
        for (int k = 0; k < ((x == 8'h02) ? 1 : cnt); k++) s.push_back(8'($urandom_range(0, 255)));
      end
    end
    model_parse(s);
    send_stream(s);
    wait_idle("rand");
    check("rand_err_op", err_op, exp_err_op);
    check("rand_err_ovr_tmo", {err_ovr, err_tmo}, 0);
    finish_case("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
